// File: rtl/if1_skid_queue.sv
// ============================================================================
// if1_skid_queue
//
// Purpose
//   Fetch-packet queue between IF1 and decode. Packets are queued in order and
//   handed to decode from the head entry one cycle after they are accepted.
//   When an accepted packet carries a serializing instruction (ibar, csr or
//   tlb), every slot after the first serializing slot is replaced by a NOP, the
//   front end is redirected to the instruction after that slot, and no further
//   packets are accepted until the serializing instruction has reached EX and
//   its completion condition has been seen. Packets already in the queue,
//   including the serializing one, keep draining to decode meanwhile.
//
// Parameters
//   NUM_INST  instructions per fetch packet (1..4)
//   DEPTH     queue entries (power of 2, >= 2)
//   N_SER     serialization channels (0 = ibar, 1 = csr, 2 = tlb)
//
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   flush            pipeline flush: empties the queue and returns to IDLE
//   in_valid/ready   upstream handshake
//   in_pc .. in_cookie   packet fields; in_inst slot 0 at the LSBs
//   in_ser           bit c*NUM_INST+k: slot k holds a channel-c serializer
//   out_valid/ready  downstream handshake
//   out_pc .. out_cookie head-entry fields (fixed defaults when empty)
//   ser_at_ex        per channel: the serializing instruction reached EX
//   ser_done         per channel: completion condition of that channel
//   redirect_valid   a serialization is in progress
//   redirect_pc      restart address after the serializing instruction
//   flush_front      kill IF0/IF1 while waiting for the serializer to reach EX
//   count            number of occupied entries
//   fsm_state        current serialization state (IDLE=0, WAIT_EX=1,
//                    WAIT_DONE=2), exported for observation
//
// Handshake
//   A transfer happens on a cycle where valid && ready are both high at the
//   rising edge. in_ready is a function of count and state only, never of
//   out_ready; out_valid is simply (count != 0). Neither side may depend on
//   the other side's ready within the same cycle.
// ============================================================================
module if1_skid_queue #(
    parameter int NUM_INST = 2,
    parameter int DEPTH    = 4,
    parameter int N_SER    = 3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,

    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_pc,
    input  logic [31:0]                   in_pc_next,
    input  logic [32*NUM_INST-1:0]        in_inst,
    input  logic [31:0]                   in_badv,
    input  logic [6:0]                    in_excp,
    input  logic [1:0]                    in_excp_flag,
    input  logic [31:0]                   in_cookie,
    input  logic [N_SER*NUM_INST-1:0]     in_ser,

    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_pc,
    output logic [31:0]                   out_pc_next,
    output logic [32*NUM_INST-1:0]        out_inst,
    output logic [31:0]                   out_badv,
    output logic [6:0]                    out_excp,
    output logic [1:0]                    out_excp_flag,
    output logic [31:0]                   out_cookie,

    input  logic [N_SER-1:0]              ser_at_ex,
    input  logic [N_SER-1:0]              ser_done,
    output logic                          redirect_valid,
    output logic [31:0]                   redirect_pc,
    output logic                          flush_front,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [1:0]                    fsm_state
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int SLOT_W = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;
    localparam int CH_W   = (N_SER > 1) ? $clog2(N_SER) : 1;
    localparam int IW     = 32*NUM_INST;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam logic [31:0] NOP_INST = 32'h0340_0000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EX   = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state;
    logic [CH_W-1:0]    ch_q;          // channel of the pending serializer
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Entry storage. Not reset: occupancy is tracked by count/pointers only.
    logic [31:0]        pc_mem      [DEPTH];
    logic [31:0]        pc_next_mem [DEPTH];
    logic [IW-1:0]      inst_mem    [DEPTH];
    logic [31:0]        badv_mem    [DEPTH];
    logic [6:0]         excp_mem    [DEPTH];
    logic [1:0]         flag_mem    [DEPTH];
    logic [31:0]        cookie_mem  [DEPTH];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic push;
    logic pop;

    assign in_ready  = (count < CNT_W'(DEPTH)) && (state == IDLE);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Serializer detection on the incoming packet.
    // The slot loop is outermost so the first hit is the lowest slot; within
    // that slot the channel loop picks the lowest channel.
    // ------------------------------------------------------------------
    logic               ser_found;
    logic [SLOT_W-1:0]  ser_slot;
    logic [CH_W-1:0]    ser_ch;

    always_comb begin
        ser_found = 1'b0;
        ser_slot  = '0;
        ser_ch    = '0;
        for (int k = 0; k < NUM_INST; k++) begin
            for (int c = 0; c < N_SER; c++) begin
                if (!ser_found && in_ser[c*NUM_INST + k]) begin
                    ser_found = 1'b1;
                    ser_slot  = SLOT_W'(k);
                    ser_ch    = CH_W'(c);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet as it will be stored: slots after the serializer become NOPs,
    // and the exception flag is dropped only if something was actually
    // replaced (a serializer in the last slot leaves the packet intact).
    // ------------------------------------------------------------------
    logic [IW-1:0]  store_inst;
    logic [1:0]     store_flag;
    logic [31:0]    slot_ext;
    logic [31:0]    redirect_calc;

    always_comb begin
        store_inst = in_inst;
        for (int k = 0; k < NUM_INST; k++) begin
            if (ser_found && (k > int'(ser_slot))) begin
                store_inst[k*32 +: 32] = NOP_INST;
            end
        end
    end

    always_comb begin
        store_flag = in_excp_flag;
        if (ser_found && (int'(ser_slot) < NUM_INST-1)) begin
            store_flag = 2'b00;
        end
    end

    // Restart right after the serializing slot; 32-bit wrap is intended.
    assign slot_ext      = 32'(ser_slot);
    assign redirect_calc = in_pc + ((slot_ext + 32'd1) << 2);

    // ------------------------------------------------------------------
    // Entry storage write. Skipped under reset/flush so a discarded packet
    // never lands in the array.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push && rstn && !flush) begin
            pc_mem[wr_ptr]      <= in_pc;
            pc_next_mem[wr_ptr] <= in_pc_next;
            inst_mem[wr_ptr]    <= store_inst;
            badv_mem[wr_ptr]    <= in_badv;
            excp_mem[wr_ptr]    <= in_excp;
            flag_mem[wr_ptr]    <= store_flag;
            cookie_mem[wr_ptr]  <= in_cookie;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and the serialization FSM.
    // Reset and flush share one path and win over every other update.
    // redirect_valid / flush_front are registered alongside the state so
    // they are glitch-free decodes of it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            state          <= IDLE;
            ch_q           <= '0;
            redirect_pc    <= RESET_PC;
            redirect_valid <= 1'b0;
            flush_front    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            // Simultaneous push and pop leaves count unchanged.
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (push && ser_found) begin
                        state          <= WAIT_EX;
                        ch_q           <= ser_ch;
                        redirect_pc    <= redirect_calc;
                        redirect_valid <= 1'b1;
                        flush_front    <= 1'b1;
                    end
                end
                WAIT_EX: begin
                    // Only the latched channel's EX arrival matters here.
                    if (ser_at_ex[ch_q]) begin
                        state       <= WAIT_DONE;
                        flush_front <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (ser_done[ch_q]) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    flush_front    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head-entry outputs, with fixed defaults while empty so decode sees a
    // harmless NOP packet at the boot address.
    // ------------------------------------------------------------------
    always_comb begin
        if (out_valid) begin
            out_pc        = pc_mem[rd_ptr];
            out_pc_next   = pc_next_mem[rd_ptr];
            out_inst      = inst_mem[rd_ptr];
            out_badv      = badv_mem[rd_ptr];
            out_excp      = excp_mem[rd_ptr];
            out_excp_flag = flag_mem[rd_ptr];
            out_cookie    = cookie_mem[rd_ptr];
        end else begin
            out_pc        = RESET_PC;
            out_pc_next   = RESET_PC + 32'd4;
            out_inst      = {NUM_INST{NOP_INST}};
            out_badv      = '0;
            out_excp      = '0;
            out_excp_flag = '0;
            out_cookie    = '0;
        end
    end

endmodule

// File: tb/tb_if1_skid_queue.sv
// Bench for if1_skid_queue at default parameters (NUM_INST=2, DEPTH=4,
// N_SER=3). A small reference model (queue of expected packets plus the
// serialization state) is stepped in tick(); each scenario task adds its own
// directed checks on top.
module tb_if1_skid_queue;
  localparam int NI    = 2;
  localparam int DEPTH = 4;
  localparam int NS    = 3;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int W     = 32*4 + 32*NI + 7 + 2;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam logic [31:0] NOP      = 32'h0340_0000;
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_EX     = 2'd1;
  localparam logic [1:0]  S_DONE   = 2'd2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_pc = '0;
  logic [31:0]       in_pc_next = '0;
  logic [32*NI-1:0]  in_inst = '0;
  logic [31:0]       in_badv = '0;
  logic [6:0]        in_excp = '0;
  logic [1:0]        in_excp_flag = '0;
  logic [31:0]       in_cookie = '0;
  logic [NS*NI-1:0]  in_ser = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc_next;
  logic [32*NI-1:0]  out_inst;
  logic [31:0]       out_badv;
  logic [6:0]        out_excp;
  logic [1:0]        out_excp_flag;
  logic [31:0]       out_cookie;
  logic [NS-1:0]     ser_at_ex = '0;
  logic [NS-1:0]     ser_done = '0;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              flush_front;
  logic [CW-1:0]     count;
  logic [1:0]        fsm_state;

  // scoreboard and reference state
  logic [W-1:0] exp_q[$];
  logic [1:0]   m_state = S_IDLE;
  int           m_ch = 0;
  logic [31:0]  m_redir = RESET_PC;
  bit           checks_on = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  if1_skid_queue #(.NUM_INST(NI), .DEPTH(DEPTH), .N_SER(NS)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_next(in_pc_next), .in_inst(in_inst),
    .in_badv(in_badv), .in_excp(in_excp), .in_excp_flag(in_excp_flag),
    .in_cookie(in_cookie), .in_ser(in_ser),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .out_inst(out_inst),
    .out_badv(out_badv), .out_excp(out_excp), .out_excp_flag(out_excp_flag),
    .out_cookie(out_cookie),
    .ser_at_ex(ser_at_ex), .ser_done(ser_done),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_front(flush_front), .count(count), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  // expected stored form of the packet currently on the in_* ports
  function automatic logic [W-1:0] cur_pkt();
    logic [32*NI-1:0] inst;
    logic [1:0] flag;
    int k;
    inst = in_inst;
    flag = in_excp_flag;
    k = -1;
    for (int s = 0; s < NI; s++)
      for (int c = 0; c < NS; c++)
        if (k < 0 && in_ser[c*NI+s]) k = s;
    if (k >= 0) begin
      for (int s = k+1; s < NI; s++) inst[s*32 +: 32] = NOP;
      if (k < NI-1) flag = 2'b00;
    end
    return {in_pc, in_pc_next, inst, in_badv, in_excp, flag, in_cookie};
  endfunction

  function automatic logic [W-1:0] empty_pkt();
    logic [32*NI-1:0] inst;
    for (int s = 0; s < NI; s++) inst[s*32 +: 32] = NOP;
    return {RESET_PC, RESET_PC + 32'd4, inst, 32'd0, 7'd0, 2'd0, 32'd0};
  endfunction

  // One clock: check DUT against the model before the edge, advance the
  // model with the driven inputs, then return 1 time unit after the edge.
  task automatic tick();
    logic [W-1:0] got;
    logic [W-1:0] want;
    bit push;
    bit pop;
    bit m_ready;
    int k;
    int ch;
    #2;
    m_ready = (exp_q.size() < DEPTH) && (m_state == S_IDLE);
    if (checks_on) begin
      n_vec++;
      if (count !== CW'(exp_q.size())) begin
        n_err++; $display("FAIL count: got %0d want %0d", count, exp_q.size());
      end
      n_vec++;
      if (out_valid !== (exp_q.size() != 0)) begin
        n_err++; $display("FAIL out_valid: got %b want %b", out_valid, exp_q.size() != 0);
      end
      n_vec++;
      if (in_ready !== m_ready) begin
        n_err++; $display("FAIL in_ready: got %b want %b", in_ready, m_ready);
      end
      n_vec++;
      if (fsm_state !== m_state) begin
        n_err++; $display("FAIL state: got %0d want %0d", fsm_state, m_state);
      end
      n_vec++;
      if (redirect_valid !== (m_state != S_IDLE)) begin
        n_err++; $display("FAIL redirect_valid: got %b want %b", redirect_valid, m_state != S_IDLE);
      end
      n_vec++;
      if (flush_front !== (m_state == S_EX)) begin
        n_err++; $display("FAIL flush_front: got %b want %b", flush_front, m_state == S_EX);
      end
      n_vec++;
      if (redirect_pc !== m_redir) begin
        n_err++; $display("FAIL redirect_pc: got %h want %h", redirect_pc, m_redir);
      end
      got  = {out_pc, out_pc_next, out_inst, out_badv, out_excp, out_excp_flag, out_cookie};
      want = (exp_q.size() != 0) ? exp_q[0] : empty_pkt();
      n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL head_pkt: got %h want %h", got, want);
      end
    end
    push = in_valid && m_ready;
    pop  = (exp_q.size() != 0) && out_ready;
    if (!rstn || flush) begin
      exp_q.delete();
      m_state = S_IDLE;
      m_redir = RESET_PC;
      m_ch = 0;
      checks_on = 1'b1;
    end else begin
      k = -1;
      ch = 0;
      for (int s = 0; s < NI; s++)
        for (int c = 0; c < NS; c++)
          if (k < 0 && in_ser[c*NI+s]) begin k = s; ch = c; end
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(cur_pkt());
      case (m_state)
        S_IDLE: if (push && k >= 0) begin
          m_state = S_EX;
          m_redir = in_pc + 32'((k+1)*4);
          m_ch = ch;
        end
        S_EX:   if (ser_at_ex[m_ch]) m_state = S_DONE;
        S_DONE: if (ser_done[m_ch]) m_state = S_IDLE;
        default: m_state = S_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // driver helpers
  task automatic set_pkt(input logic [31:0] pc, input logic [NS*NI-1:0] ser);
    in_valid = 1'b1;
    in_pc = pc;
    in_pc_next = pc + 32'd8;
    for (int s = 0; s < NI; s++) in_inst[s*32 +: 32] = $urandom;
    in_badv = $urandom;
    in_excp = 7'($urandom);
    in_excp_flag = 2'($urandom_range(1, 3));
    in_cookie = $urandom;
    in_ser = ser;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_ser = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    n_vec++;
    if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_hs: got cnt=%0d ov=%b ir=%b want 0 0 1", count, out_valid, in_ready);
    end
    n_vec++;
    if (redirect_valid !== 1'b0 || flush_front !== 1'b0 || redirect_pc !== RESET_PC) begin
      n_err++; $display("FAIL reset_redir: got rv=%b ff=%b pc=%h want 0 0 %h", redirect_valid, flush_front, redirect_pc, RESET_PC);
    end
    n_vec++;
    if (out_pc !== RESET_PC || out_pc_next !== 32'h1c00_0004 || out_inst !== {NOP, NOP}
        || out_badv !== 0 || out_excp !== 0 || out_excp_flag !== 0 || out_cookie !== 0) begin
      n_err++; $display("FAIL reset_out: got pc=%h pcn=%h inst=%h", out_pc, out_pc_next, out_inst);
    end
    tick();
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_pkt(32'h1c00_1000 + 32'(i*16), '0);
      if (i == 4) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++; $display("FAIL full_ready: got %b want 0", in_ready);
        end
      end
      tick();
    end
    idle_in();
    n_vec++;
    if (count !== CW'(4)) begin
      n_err++; $display("FAIL full_count: got %0d want 4", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        n_vec++;
        if (out_pc !== 32'h1c00_1000) begin
          n_err++; $display("FAIL drain_first: got %h want 1c001000", out_pc);
        end
      end
      tick();
      n_vec++;
      if (count !== CW'(3-i)) begin
        n_err++; $display("FAIL drain_count: got %0d want %0d", count, 3-i);
      end
      if (i == 0) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++; $display("FAIL ready_after_pop: got %b want 1", in_ready);
        end
      end
    end
    tick();
  endtask

  task automatic test_wrap_simul();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_pkt(32'h1c00_2000 + 32'(i*4), '0);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_pkt(32'h1c00_2100 + 32'(i*4), '0);
      tick();
      n_vec++;
      if (count !== CW'(3)) begin
        n_err++; $display("FAIL wrap_count: got %0d want 3", count);
      end
    end
    idle_in();
    tick(); tick();
    // count==1 with push+pop
    set_pkt(32'h1c00_2200, '0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (count !== CW'(1)) begin
        n_err++; $display("FAIL one_count: got %0d want 1", count);
      end
      set_pkt(32'h1c00_2204 + 32'(i*4), '0);
    end
    idle_in();
    tick(); tick();
  endtask

  task automatic test_truncation();
    out_ready = 1'b0;
    set_pkt(32'h1c00_0100, 6'b000100);  // csr, slot 0
    in_inst = {32'h1111_1111, 32'h2222_2222};
    in_excp_flag = 2'b11;
    tick();
    idle_in();
    n_vec++;
    if (out_inst !== {NOP, 32'h2222_2222} || out_excp_flag !== 2'b00) begin
      n_err++; $display("FAIL trunc_pkt: got %h/%b want %h/00", out_inst, out_excp_flag, {NOP, 32'h2222_2222});
    end
    n_vec++;
    if (redirect_pc !== 32'h1c00_0104 || flush_front !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL trunc_ctl: got pc=%h ff=%b ir=%b want 1c000104 1 0", redirect_pc, flush_front, in_ready);
    end
    ser_at_ex = 3'b010;
    tick();
    ser_at_ex = '0;
    ser_done = 3'b010;
    tick();
    ser_done = '0;
    out_ready = 1'b1;
    tick();
    // serializer in the last slot: nothing replaced, flag kept
    set_pkt(32'h1c00_0200, 6'b101000);  // csr and tlb on slot 1 -> csr
    in_excp_flag = 2'b10;
    out_ready = 1'b0;
    tick();
    idle_in();
    n_vec++;
    if (redirect_pc !== 32'h1c00_0208 || out_excp_flag !== 2'b10) begin
      n_err++; $display("FAIL last_slot: got pc=%h flag=%b want 1c000208 10", redirect_pc, out_excp_flag);
    end
    ser_at_ex = 3'b100;
    out_ready = 1'b1;
    tick();
    ser_at_ex = 3'b010;
    tick();
    ser_at_ex = '0;
    ser_done = 3'b010;
    tick();
    ser_done = '0;
    tick();
  endtask

  task automatic test_channel_isolation();
    out_ready = 1'b0;
    set_pkt(32'h1c00_0300, 6'b010000);  // tlb, slot 0
    tick();
    idle_in();
    ser_at_ex = 3'b010;
    ser_done = 3'b100;
    tick();
    n_vec++;
    if (flush_front !== 1'b1) begin
      n_err++; $display("FAIL iso_ex: got ff=%b want 1", flush_front);
    end
    ser_at_ex = 3'b100;
    ser_done = '0;
    tick();
    n_vec++;
    if (flush_front !== 1'b0 || redirect_valid !== 1'b1) begin
      n_err++; $display("FAIL iso_done: got ff=%b rv=%b want 0 1", flush_front, redirect_valid);
    end
    ser_done = 3'b011;
    tick();
    ser_at_ex = '0;
    ser_done = 3'b100;
    tick();
    ser_done = '0;
    n_vec++;
    if (redirect_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL iso_idle: got rv=%b ir=%b want 0 1", redirect_valid, in_ready);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_pkt(32'h1c00_0400, '0);
    tick();
    set_pkt(32'h1c00_0410, 6'b000100);
    tick();
    idle_in();
    ser_at_ex = 3'b010;
    tick();
    ser_at_ex = '0;
    n_vec++;
    if (count !== CW'(2) || redirect_valid !== 1'b1 || flush_front !== 1'b0) begin
      n_err++; $display("FAIL pre_flush: got cnt=%0d rv=%b ff=%b want 2 1 0", count, redirect_valid, flush_front);
    end
    flush = 1'b1;
    set_pkt(32'h1c00_0420, '0);
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    idle_in();
    n_vec++;
    if (count !== 0 || out_valid !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== RESET_PC || out_pc !== RESET_PC) begin
      n_err++; $display("FAIL flush: got cnt=%0d ov=%b rv=%b rpc=%h opc=%h", count, out_valid, redirect_valid, redirect_pc, out_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid_ser();
    out_ready = 1'b0;
    set_pkt(32'h1c00_0500, 6'b000001);  // ibar, slot 0
    tick();
    idle_in();
    n_vec++;
    if (flush_front !== 1'b1) begin
      n_err++; $display("FAIL mid_ser_setup: got ff=%b want 1", flush_front);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_vec++;
    if (redirect_valid !== 1'b0 || flush_front !== 1'b0 || count !== 0 || redirect_pc !== RESET_PC) begin
      n_err++; $display("FAIL mid_ser_reset: got rv=%b ff=%b cnt=%0d rpc=%h", redirect_valid, flush_front, count, redirect_pc);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0)
        set_pkt(32'h1c01_0000 + 32'(i*16),
                ($urandom_range(0, 3) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0);
      else
        idle_in();
      out_ready = ($urandom_range(0, 3) != 0);
      ser_at_ex = 3'($urandom_range(0, 7));
      ser_done = 3'($urandom_range(0, 7));
      flush = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b1;
    idle_in();
    tick();
    flush = 1'b0;
    ser_at_ex = '0;
    ser_done = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap_simul();
    test_truncation();
    test_channel_isolation();
    test_flush();
    test_reset_mid_ser();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/if1_skid_queue.md
IF1_SKID_QUEUE -- requirements
Module: if1_skid_queue

Interface
REQ-001 SHALL have parameter NUM_INST, default 2: instructions per fetch packet, range 1..4.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries, a power of 2, at least 2.
REQ-003 SHALL have parameter N_SER, default 3: serialization channels (0 = ibar, 1 = csr, 2 = tlb).
REQ-004 SHALL use one clock and a synchronous, active-low reset: ports clk and rstn.
REQ-005 SHALL have ports: clk in 1, clock; rstn in 1, synchronous active-low reset; flush in 1, pipeline flush.
REQ-006 SHALL have input-side ports:
- in_valid in 1; in_ready out 1.
- in_pc in 32; in_pc_next in 32.
- in_inst in 32*NUM_INST, slot 0 at the LSBs.
- in_badv in 32; in_excp in 7; in_excp_flag in 2; in_cookie in 32.
- in_ser in N_SER*NUM_INST: bit c*NUM_INST+k means slot k carries a channel-c serializing instruction.
REQ-007 SHALL have output-side ports:
- out_valid out 1; out_ready in 1.
- out_pc, out_pc_next, out_inst, out_badv, out_excp, out_excp_flag, out_cookie: same widths as the matching in_* ports.
REQ-008 SHALL have control ports:
- ser_at_ex in N_SER: the channel-c instruction has reached EX.
- ser_done in N_SER: the channel-c completion condition (cache idle, csr done, tlb done).
- redirect_valid out 1; redirect_pc out 32; flush_front out 1, kill IF0/IF1.
- count out $clog2(DEPTH+1).

Function
REQ-009 Push SHALL occur on in_valid&&in_ready; pop SHALL occur on out_valid&&out_ready.
REQ-010 in_ready SHALL equal (count<DEPTH)&&(state==IDLE); it is combinational, with no dependence on out_ready.
REQ-011 out_valid SHALL equal (count!=0).
REQ-012 out_* SHALL be driven from the head entry.
REQ-013 When the queue is empty, out_* SHALL be: out_pc 0x1c000000, out_pc_next 0x1c000004, every out_inst slot 0x03400000 (NOP), all other outputs 0.
REQ-014 Latency SHALL be 1 cycle: a packet pushed at edge N is visible at out_* after edge N; there is no combinational bypass.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH.
REQ-016 When push and pop occur in the same cycle, count SHALL be unchanged; this includes count==DEPTH-1 and count==1.
REQ-017 When full, push SHALL be impossible; a pop that cycle SHALL make in_ready high on the following cycle.
REQ-018 On an accepted push, k SHALL be the lowest slot with any in_ser bit set; if none is set, the packet SHALL be stored unchanged.
REQ-019 If k exists, the block SHALL:
- store the packet with slots k+1..NUM_INST-1 replaced by NOP;
- store in_excp_flag as 00 if any slot was replaced;
- set redirect_pc to in_pc + 4*(k+1), modulo 2^32;
- latch ch as the lowest channel set in slot k;
- set state to WAIT_EX.
REQ-020 The FSM SHALL have states IDLE, WAIT_EX and WAIT_DONE.
- IDLE -> WAIT_EX on a serializing push (REQ-019).
- WAIT_EX -> WAIT_DONE when ser_at_ex[ch]=1.
- WAIT_DONE -> IDLE when ser_done[ch]=1.
REQ-021 In WAIT_EX, ser_done SHALL be ignored; in WAIT_DONE, ser_at_ex SHALL be ignored; channels other than ch SHALL be ignored in both states.
REQ-022 flush_front SHALL be 1 exactly when state==WAIT_EX.
REQ-023 redirect_valid SHALL be 1 exactly when state!=IDLE; redirect_pc SHALL be stable while redirect_valid is high.
REQ-024 Popping SHALL continue in every state, so packets already queued, including the serializing packet, drain to decode.
REQ-025 flush SHALL, at the next edge, take priority over any same-cycle push, pop or FSM transition, and SHALL:
- clear pointers and count;
- set state to IDLE;
- set redirect_pc to 0x1c000000.
REQ-026 A packet offered in the same cycle as flush SHALL be discarded.

Reset
REQ-027 While rstn=0 at an edge, the block SHALL apply the REQ-025 actions.
REQ-028 After reset, outputs SHALL be: count 0, out_valid 0, in_ready 1, redirect_valid 0, flush_front 0, redirect_pc 0x1c000000, and empty-queue out_* per REQ-013.
REQ-029 Reset asserted mid-serialization SHALL return the FSM to IDLE with no redirect pulse.

Verification
REQ-030 Fill/drain: DEPTH=4, out_ready=0, push 5 packets -> 4 accepted, in_ready=0, count=4; then out_ready=1 -> packets drain in order, count reaches 0 after 4 cycles.
REQ-031 Wrap plus simultaneous push/pop: with count=3, run 8 cycles of push+pop -> count stays 3, output PCs stay in push order across pointer wrap.
REQ-032 Truncation, NUM_INST=2: push pc=0x1c000100 with in_ser slot 0 on csr -> stored inst1=0x03400000, excp_flag=00, redirect_pc=0x1c000104, state=WAIT_EX, in_ready=0, flush_front=1.
REQ-033 Channel isolation: in WAIT_EX(tlb), pulse ser_at_ex[csr] and ser_done[tlb] -> state unchanged; then ser_at_ex[tlb] -> WAIT_DONE, flush_front=0; then ser_done[tlb] -> IDLE, in_ready=1.
REQ-034 Flush mid-serialization: in WAIT_DONE with count=2, assert flush together with in_valid and out_ready -> next cycle count=0, IDLE, redirect_valid=0, redirect_pc=0x1c000000, offered packet absent.
